// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

    // Host transmitter sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_FINISH,
        S_ERR
    } ps2_tx_state_t;

    // Device falling-edge indices within one host-to-device frame.
    localparam logic [3:0] EDGE_LAST_DATA = 4'd8;
    localparam logic [3:0] EDGE_PARITY    = 4'd9;
    localparam logic [3:0] EDGE_STOP      = 4'd10;
    localparam logic [3:0] EDGE_ACK       = 4'd11;

    // Default timing, in system clock cycles at 100 MHz.
    localparam int DEF_INHIBIT_CYCLES       = 12000;
    localparam int DEF_DATA_LEAD_CYCLES     = 16;
    localparam int DEF_START_TIMEOUT_CYCLES = 1_500_000;
    localparam int DEF_XFER_TIMEOUT_CYCLES  = 200_000;
    localparam int DEF_FILTER_LEN           = 8;

    // Keyboard command bytes and device response bytes.
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Edge count increment that sticks at the ack edge.
    function automatic logic [3:0] edge_inc(input logic [3:0] n);
        return (n >= EDGE_ACK) ? EDGE_ACK : n + 4'd1;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, glitch filter and falling-edge pulse for one PS/2 line.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int              CW       = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // A new level is accepted on the FILTER_LEN-th consecutive differing sample.
    assign w_accept = (r_sync2 != r_level) && (r_cnt == CNT_LAST);
    assign o_level  = r_level;
    assign o_fall   = w_accept && r_level;

    // Two-flop synchronizer; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
        end
    end

    // Run-length filter: any sample agreeing with the held level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting, ack check, timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
    parameter int DATA_LEAD_CYCLES     = DEF_DATA_LEAD_CYCLES,
    parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
    parameter int XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES,
    parameter int FILTER_LEN           = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA
);

    localparam int INH_W   = cnt_width(INHIBIT_CYCLES);
    localparam int START_W = cnt_width(START_TIMEOUT_CYCLES);
    localparam int XFER_W  = cnt_width(XFER_TIMEOUT_CYCLES);

    localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [XFER_W-1:0]  XFER_LAST  = XFER_W'(XFER_TIMEOUT_CYCLES - 1);

    // The start bit goes out during the tail end of the inhibit window.
    localparam bit HAS_LEAD = (DATA_LEAD_CYCLES > 0);
    localparam int LEAD_START_I = (DATA_LEAD_CYCLES >= INHIBIT_CYCLES) ? 0
                                : INHIBIT_CYCLES - DATA_LEAD_CYCLES;
    localparam logic [INH_W-1:0] LEAD_START = INH_W'(LEAD_START_I);

    ps2_tx_state_t      r_state;
    ps2_tx_state_t      w_next;

    logic [7:0]         r_byte;
    logic               r_parity;
    logic               r_bit;
    logic [3:0]         r_edges;
    logic [INH_W-1:0]   r_inh_cnt;
    logic [START_W-1:0] r_start_cnt;
    logic [XFER_W-1:0]  r_xfer_cnt;

    logic               w_clk_level;
    logic               w_clk_fall;
    logic               w_data_level;
    logic               w_data_fall;
    logic               w_accept;
    logic               w_start_expired;
    logic               w_xfer_expired;
    logic               w_lines_high;
    logic [3:0]         w_edge_next;
    logic               w_clk_low;
    logic               w_data_low;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .i_line  (PS2_CLK),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .i_line  (PS2_DATA),
        .o_level (w_data_level),
        .o_fall  (w_data_fall)
    );

    // Handshake and status; tx_ready is held low while reset is asserted.
    assign tx_ready        = (r_state == S_IDLE) && rst;
    assign busy            = (r_state != S_IDLE);
    assign w_accept        = tx_valid && tx_ready;
    assign w_start_expired = (r_start_cnt == START_LAST);
    assign w_xfer_expired  = (r_xfer_cnt == XFER_LAST);
    assign w_lines_high    = w_clk_level && w_data_level;
    assign w_edge_next     = edge_inc(r_edges);

    // Line drivers are decoded straight from state so reset releases them at once.
    assign w_clk_low  = (r_state == S_INHIBIT);
    assign w_data_low = ((r_state == S_INHIBIT) && HAS_LEAD && (r_inh_cnt >= LEAD_START))
                     || (r_state == S_REQ)
                     || ((r_state == S_SHIFT) && !r_bit);

    assign PS2_CLK  = w_clk_low  ? 1'b0 : 1'bz;
    assign PS2_DATA = w_data_low ? 1'b0 : 1'bz;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the completion pulses.
    always_comb begin
        w_next  = r_state;
        tx_done = 1'b0;
        tx_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_clk_fall) begin
                    w_next = S_SHIFT;
                end else if (w_start_expired) begin
                    w_next = S_ERR;
                end
            end
            S_SHIFT: begin
                if (w_clk_fall && (w_edge_next == EDGE_STOP)) begin
                    w_next = S_ACK;
                end else if (w_xfer_expired) begin
                    w_next = S_ERR;
                end
            end
            S_ACK: begin
                if (w_clk_fall) begin
                    w_next = w_data_level ? S_ERR : S_FINISH;
                end else if (w_xfer_expired) begin
                    w_next = S_ERR;
                end
            end
            S_FINISH: begin
                if (w_lines_high) begin
                    w_next  = S_IDLE;
                    tx_done = 1'b1;
                end else if (w_xfer_expired) begin
                    w_next = S_ERR;
                end
            end
            S_ERR: begin
                w_next  = S_IDLE;
                tx_done = 1'b1;
                tx_err  = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latched byte, edge count, driven bit and the three timing counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte      <= '0;
            r_parity    <= 1'b0;
            r_bit       <= 1'b1;
            r_edges     <= '0;
            r_inh_cnt   <= '0;
            r_start_cnt <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bit   <= 1'b1;
                    r_edges <= '0;
                    if (w_accept) begin
                        r_byte    <= tx_data;
                        r_parity  <= ~^tx_data;
                        r_inh_cnt <= '0;
                    end
                end
                S_INHIBIT: begin
                    r_inh_cnt   <= r_inh_cnt + 1'b1;
                    r_start_cnt <= '0;
                end
                S_REQ: begin
                    r_start_cnt <= r_start_cnt + 1'b1;
                    if (w_clk_fall) begin
                        r_edges    <= 4'd1;
                        r_bit      <= r_byte[0];
                        r_xfer_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_xfer_cnt <= r_xfer_cnt + 1'b1;
                    if (w_clk_fall) begin
                        r_edges <= w_edge_next;
                        if (w_edge_next <= EDGE_LAST_DATA) begin
                            r_bit <= r_byte[r_edges[2:0]];
                        end else if (w_edge_next == EDGE_PARITY) begin
                            r_bit <= r_parity;
                        end else begin
                            r_bit <= 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    r_xfer_cnt <= r_xfer_cnt + 1'b1;
                    r_bit      <= 1'b1;
                    if (w_clk_fall) begin
                        r_edges <= w_edge_next;
                    end
                end
                S_FINISH: begin
                    r_xfer_cnt <= r_xfer_cnt + 1'b1;
                    r_bit      <= 1'b1;
                end
                default: begin
                    r_bit <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, …) from the FPGA to the keyboard over the same open-drain PS2_CLK/PS2_DATA pair that the keyboard decoder listens on. It runs the full request-to-send sequence, bit shifting, odd parity, stop bit, device-ack check and timeouts. The device's response byte (0xFA/0xFE) arrives through the existing receive path; `busy` lets the top level gate it.

## Interface
- `INHIBIT_CYCLES`, default 12000: clk cycles PS2_CLK is held low for request-to-send (≥100 µs at 100 MHz).
- `DATA_LEAD_CYCLES`, default 16: final cycles of inhibit during which PS2_DATA is also driven low.
- `START_TIMEOUT_CYCLES`, default 1_500_000: maximum wait for the first device falling edge after the clock is released (15 ms).
- `XFER_TIMEOUT_CYCLES`, default 200_000: maximum time from the first falling edge to the ack (2 ms).
- `FILTER_LEN`, default 8: consecutive equal synchronized samples needed to accept a line level.
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: reset, asynchronous, active-low.
- `tx_data` input 8: byte to send, LSB first.
- `tx_valid` input 1: request; a byte is accepted when `tx_valid && tx_ready`.
- `tx_ready` output 1: high only in IDLE.
- `busy` output 1: high from acceptance until `tx_done`.
- `tx_done` output 1: one-cycle pulse at the end of every accepted transfer.
- `tx_err` output 1: one-cycle pulse coincident with `tx_done` on a failed transfer.
- `PS2_CLK` inout 1: open-drain; driven 0 or Z only.
- `PS2_DATA` inout 1: open-drain; driven 0 or Z only.

## Operation
- Each line passes through a 2-flop synchronizer, then a FILTER_LEN glitch filter, then falling-edge detection (`fall` is a one-cycle pulse).
- Byte and odd parity (`~^tx_data`) are latched on acceptance. A new `tx_valid` is ignored while `busy`.
- **IDLE:** both lines released.
  - On acceptance go to INHIBIT and clear the counter.
- **INHIBIT:** drive PS2_CLK low for INHIBIT_CYCLES cycles.
  - PS2_DATA is also driven low during the last DATA_LEAD_CYCLES of that window (start bit).
  - Then go to REQ.
- **REQ:** PS2_CLK released; PS2_DATA held low.
  - First `fall` goes to SHIFT with edge count = 1, and drives data bit 0.
  - If START_TIMEOUT_CYCLES elapse with no `fall`, go to ERR.
- **SHIFT:** each `fall` increments the edge count n, and the driven level updates in the same cycle as `fall`:
  - n = 2..8: drive data bit n−1.
  - n = 9: drive parity.
  - n = 10: release PS2_DATA (stop bit = 1) and go to ACK.
  - Bit value 1 means release; bit value 0 means drive low.
- **ACK:** on the next `fall` (edge 11), sample the filtered PS2_DATA.
  - Low: go to FINISH.
  - High: go to ERR.
- **FINISH:** wait until both filtered lines are high, then pulse `tx_done` and go to IDLE.
- **ERR:** release both lines, pulse `tx_done` and `tx_err`, then go to IDLE.
- The XFER_TIMEOUT_CYCLES counter runs from SHIFT entry. Expiry in SHIFT, ACK or FINISH goes to ERR.
- Host inhibit has priority: if the keyboard is transmitting when a byte is accepted, INHIBIT aborts it per protocol.

## Timing
- **Reset:** `tx_ready=1` after release (0 while `rst` is low), `busy=0`, `tx_done=0`, `tx_err=0`, both lines Z, state IDLE.
- **Reset mid-operation:** lines released asynchronously in the same instant, no `tx_done`, counters cleared.
- **Acceptance:** `tx_ready` drops the cycle after acceptance, and PS2_CLK is driven low from that cycle.
- **Edge response:** the driven data level changes 2+FILTER_LEN cycles after a physical falling edge. This is well inside the ≥30 µs clock-low half period.
- **Filtered glitches:** pulses shorter than FILTER_LEN cycles produce no `fall` and do not advance the edge count.
- **Turnaround:** `tx_ready` returns 1 the cycle after the `tx_done` pulse. Back-to-back bytes each repeat the full INHIBIT.
- **Width rules:**
  - Edge count is 4 bits, saturating at 11.
  - Timeout counters are sized `$clog2` of their parameter.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, FINISH, ERR);
  - the edge-index constants (LAST_DATA=8, PARITY=9, STOP=10, ACK=11);
  - the default timing constants;
  - the command/response codes 0xED, 0xFF, 0xF4, 0xFA, 0xFE, 0xAA.
- Sub-module `ps2_line_filter` (synchronizer, glitch filter, fall pulse), instantiated once per line. The receive path can reuse it later.

## Test plan
Simulation parameters: INHIBIT_CYCLES=200, START_TIMEOUT=5000, XFER_TIMEOUT=20000, FILTER_LEN=4. The device model clocks at a 60-cycle half period and samples PS2_DATA on rising edges.

1. Send 0xED, device model acks: PS2_CLK low ≥200 cycles; the model samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; `tx_done`=1 with `tx_err`=0.
2. Send 0x01 then 0xFF back-to-back with `tx_valid` held: parity 0 then 1; exactly two `tx_done` pulses; `tx_valid` is ignored while `busy`.
3. Device never clocks: `tx_err` and `tx_done` pulse 5000 cycles after REQ entry; both lines Z.
4. Device leaves DATA high on edge 11: `tx_err`=1, and `tx_ready`=1 the next cycle.
5. `rst` driven low after edge 5 of 0xED: both lines Z immediately, no `tx_done`; after release a new 0xF4 completes with no error.
6. 2-cycle low glitch on PS2_CLK during SHIFT: edge count unchanged, and the transfer of 0xED still completes correctly.
